// File: rtl/pll_phase_ctrl.sv
// Phase-step and reset sequencer for the GTP_PLL_E3 clock generator.
// Define PLL_LOCK_WATCHDOG_EN to re-run PLL reset when lock is lost while idle.
module pll_phase_ctrl #(
    parameter int unsigned STEP_PULSE_W = 2,
    parameter int unsigned STEP_GAP     = 8,
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_sel,
    input  logic       req_dir,
    input  logic [7:0] req_steps,
    output logic       done,
    output logic       busy,
    output logic       err_timeout,
    output logic       err_sel,
    output logic       lock_ok,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic [2:0] phase_sel,
    output logic       phase_dir,
    output logic       phase_step_n,
    output logic       load_phase
);

    typedef enum logic [2:0] {
        StReset,
        StWaitLock,
        StIdle,
        StLoad,
        StStepLo,
        StStepHi,
        StDone
    } state_e;

    localparam logic [15:0] RstLast     = 16'(RST_HOLD - 1);
    localparam logic [15:0] PulseLast   = 16'(STEP_PULSE_W - 1);
    localparam logic [15:0] GapLast     = 16'(STEP_GAP - 1);
    localparam logic [15:0] TimeoutLast = 16'(LOCK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  step_cnt_q, step_cnt_d;
    logic        pending_q, pending_d;
    logic [2:0]  sel_q, sel_d;
    logic        dir_q, dir_d;
    logic        err_timeout_q, err_timeout_d;
    logic        err_sel_q, err_sel_d;
    logic        lock_meta_q, lock_ok_q;
    logic        accept;

    // pll_lock is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_ok_q   <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_ok_q   <= lock_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StReset;
            cnt_q         <= 16'd0;
            step_cnt_q    <= 8'd0;
            pending_q     <= 1'b0;
            sel_q         <= 3'd0;
            dir_q         <= 1'b0;
            err_timeout_q <= 1'b0;
            err_sel_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            step_cnt_q    <= step_cnt_d;
            pending_q     <= pending_d;
            sel_q         <= sel_d;
            dir_q         <= dir_d;
            err_timeout_q <= err_timeout_d;
            err_sel_q     <= err_sel_d;
        end
    end

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 16'd1;
        step_cnt_d    = step_cnt_q;
        pending_d     = pending_q;
        sel_d         = sel_q;
        dir_d         = dir_q;
        err_timeout_d = err_timeout_q;
        err_sel_d     = 1'b0;
        unique case (state_q)
            StReset: begin
                if (cnt_q == RstLast) begin
                    state_d = StWaitLock;
                    cnt_d   = 16'd0;
                end
            end
            StWaitLock: begin
                if (lock_ok_q) begin
                    state_d = pending_q ? StDone : StIdle;
                    cnt_d   = 16'd0;
                end else if (cnt_q == TimeoutLast) begin
                    // Retry from reset; any in-flight request is abandoned
                    state_d       = StReset;
                    cnt_d         = 16'd0;
                    pending_d     = 1'b0;
                    err_timeout_d = 1'b1;
                end
            end
            StIdle: begin
                cnt_d = 16'd0;
                if (accept) begin
                    if (req_sel > 3'd4) begin
                        err_sel_d = 1'b1;
                    end else begin
                        sel_d      = req_sel;
                        dir_d      = req_dir;
                        step_cnt_d = req_steps;
                        if (req_steps == 8'd0) begin
                            state_d = StDone;
                        end else begin
                            state_d   = StLoad;
                            pending_d = 1'b1;
                        end
                    end
                end
`ifdef PLL_LOCK_WATCHDOG_EN
                else if (!lock_ok_q) begin
                    state_d = StReset;
                end
`endif
            end
            StLoad: begin
                state_d = StStepLo;
                cnt_d   = 16'd0;
            end
            StStepLo: begin
                if (cnt_q == PulseLast) begin
                    state_d = StStepHi;
                    cnt_d   = 16'd0;
                end
            end
            StStepHi: begin
                if (cnt_q == GapLast) begin
                    cnt_d      = 16'd0;
                    step_cnt_d = step_cnt_q - 8'd1;
                    state_d    = (step_cnt_q == 8'd1) ? StWaitLock : StStepLo;
                end
            end
            StDone: begin
                state_d   = StIdle;
                cnt_d     = 16'd0;
                pending_d = 1'b0;
            end
            default: begin
                state_d = StReset;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Outputs decode directly from state so async reset reaches the pins at once
    always_comb begin
        req_ready    = (state_q == StIdle) && lock_ok_q;
        busy         = (state_q != StIdle);
        pll_rst      = (state_q == StReset);
        load_phase   = (state_q == StLoad);
        phase_step_n = (state_q != StStepLo);
        done         = (state_q == StDone);
        phase_sel    = sel_q;
        phase_dir    = dir_q;
        lock_ok      = lock_ok_q;
        err_timeout  = err_timeout_q;
        err_sel      = err_sel_q;
    end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Scoreboard bench for pll_phase_ctrl: done/err_sel events are predicted at drive time
// and matched by cycle as the DUT emits them.
module tb_pll_phase_ctrl;

    localparam int PW   = 2;
    localparam int GAP  = 8;
    localparam int HOLD = 16;
    localparam int TMO  = 65535;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_sel = 3'd0;
    logic       req_dir = 1'b0;
    logic [7:0] req_steps = 8'd0;
    logic       done, busy, err_timeout, err_sel, lock_ok;
    logic       pll_lock = 1'b0;
    logic       pll_rst;
    logic [2:0] phase_sel;
    logic       phase_dir, phase_step_n, load_phase;

    pll_phase_ctrl #(
        .STEP_PULSE_W(PW),
        .STEP_GAP    (GAP),
        .RST_HOLD    (HOLD),
        .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sel     (req_sel),
        .req_dir     (req_dir),
        .req_steps   (req_steps),
        .done        (done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_sel     (err_sel),
        .lock_ok     (lock_ok),
        .pll_lock    (pll_lock),
        .pll_rst     (pll_rst),
        .phase_sel   (phase_sel),
        .phase_dir   (phase_dir),
        .phase_step_n(phase_step_n),
        .load_phase  (load_phase)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // kind 0 = done pulse, kind 1 = err_sel pulse
    typedef struct {
        int kind;
        int cyc;
    } ev_t;
    ev_t sb[$];

    int   load_cnt = 0;
    int   load_cyc = 0;
    int   lo_cnt = 0;
    int   rst_cnt = 0;
    int   busy_cnt = 0;
    int   falls[$];
    logic prev_step_n = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (load_phase) begin
                load_cnt++;
                load_cyc = cyc;
            end
            if (!phase_step_n) lo_cnt++;
            if (!phase_step_n && prev_step_n) falls.push_back(cyc);
            if (pll_rst) rst_cnt++;
            if (busy) busy_cnt++;
            if (done || err_sel) begin
                int   kind;
                ev_t  ev;
                kind = done ? 0 : 1;
                if (sb.size() == 0) begin
                    check_eq("unexpected_event_kind", kind, 255);
                end else begin
                    ev = sb.pop_front();
                    check_eq("event_kind", kind, ev.kind);
                    check_eq("event_cycle", cyc, ev.cyc);
                end
            end
        end
        prev_step_n = phase_step_n;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int budget, input string tag);
        int n = 0;
        while (!req_ready && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, req_ready, 1);
    endtask

    // Drive one request in the current (ready) cycle and predict its event.
    task automatic send(input int sel, input int dir, input int steps, input bit exp_done,
                        output int t);
        ev_t ev;
        load_cnt = 0;
        lo_cnt   = 0;
        falls.delete();
        req_valid = 1'b1;
        req_sel   = 3'(sel);
        req_dir   = 1'(dir);
        req_steps = 8'(steps);
        t = cyc;
        if (sel > 4) begin
            ev.kind = 1;
            ev.cyc  = t + 1;
            sb.push_back(ev);
        end else if (steps == 0) begin
            ev.kind = 0;
            ev.cyc  = t + 1;
            sb.push_back(ev);
        end else if (exp_done) begin
            ev.kind = 0;
            ev.cyc  = t + 3 + steps * (PW + GAP);
            sb.push_back(ev);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("scoreboard_drain", sb.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        int rel;
        int lock_c;
        int n;

        #2 rst_n = 1'b0;
        repeat (3) tick();
        check_eq("rst_pll_rst", pll_rst, 1);
        check_eq("rst_step_n", phase_step_n, 1);
        check_eq("rst_load", load_phase, 0);
        check_eq("rst_sel", phase_sel, 0);
        check_eq("rst_dir", phase_dir, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_err_timeout", err_timeout, 0);
        check_eq("rst_err_sel", err_sel, 0);
        check_eq("rst_lock_ok", lock_ok, 0);

        // Power-up
        rst_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel = cyc;
        while (cyc < rel + 30) tick();
        pll_lock = 1'b1;
        lock_c = cyc;
        wait_ready(20, "pwr_ready");
        check_eq("pwr_rst_cycles", rst_cnt, HOLD);
        check_eq("pwr_ready_latency", cyc - lock_c, 3);
        check_eq("pwr_busy", busy, 0);

        // sel=2 dir=1 steps=3
        send(2, 1, 3, 1'b1, t);
        drain(100);
        check_eq("s3_load_cnt", load_cnt, 1);
        check_eq("s3_load_cyc", load_cyc, t + 1);
        check_eq("s3_lo_cycles", lo_cnt, 3 * PW);
        check_eq("s3_pulses", falls.size(), 3);
        if (falls.size() == 3) begin
            for (int k = 0; k < 3; k++) check_eq("s3_pulse_start", falls[k], t + 2 + k * (PW + GAP));
        end
        check_eq("s3_sel", phase_sel, 2);
        check_eq("s3_dir", phase_dir, 1);
        check_eq("s3_ready_during_done", req_ready, 0);
        tick();
        check_eq("s3_ready_after", req_ready, 1);

        // steps=0
        send(4, 0, 0, 1'b1, t);
        drain(10);
        check_eq("s0_load_cnt", load_cnt, 0);
        check_eq("s0_lo_cycles", lo_cnt, 0);
        tick();
        check_eq("s0_ready_t2", req_ready, 1);
        check_eq("s0_sel", phase_sel, 4);
        check_eq("s0_dir", phase_dir, 0);

        // sel=6 rejected
        busy_cnt = 0;
        send(6, 1, 5, 1'b1, t);
        repeat (6) tick();
        check_eq("sel6_busy_cycles", busy_cnt, 0);
        check_eq("sel6_events_left", sb.size(), 0);
        check_eq("sel6_load_cnt", load_cnt, 0);
        check_eq("sel6_lo_cycles", lo_cnt, 0);
        check_eq("sel6_ready", req_ready, 1);

        // single step
        send(0, 0, 1, 1'b1, t);
        drain(40);
        check_eq("s1_pulses", falls.size(), 1);
        check_eq("s1_lo_cycles", lo_cnt, PW);
        check_eq("s1_sel", phase_sel, 0);
        check_eq("s1_dir", phase_dir, 0);

        // maximum step count, no wrap
        wait_ready(5, "s255_ready");
        send(3, 1, 255, 1'b1, t);
        drain(3000);
        check_eq("s255_pulses", falls.size(), 255);
        check_eq("s255_lo_cycles", lo_cnt, 255 * PW);
        if (falls.size() == 255) check_eq("s255_last_start", falls[254], t + 2 + 254 * (PW + GAP));
        check_eq("s255_sel", phase_sel, 3);

        // lock lost mid-sequence, never restored -> timeout and reset retry
        wait_ready(5, "tmo_ready");
        rst_cnt = 0;
        send(1, 0, 2, 1'b0, t);
        while (cyc < t + 5) tick();
        pll_lock = 1'b0;
        check_eq("tmo_err_before", err_timeout, 0);
        n = 0;
        while (!pll_rst && n < 70000) begin
            tick();
            n++;
        end
        check_eq("tmo_rst_cycle", cyc, t + 22 + TMO);
        check_eq("tmo_err_set", err_timeout, 1);
        check_eq("tmo_pulses", falls.size(), 2);
        n = 0;
        while (pll_rst && n < 100) begin
            tick();
            n++;
        end
        check_eq("tmo_rst_cycles", rst_cnt, HOLD);
        pll_lock = 1'b1;
        wait_ready(40, "tmo_recover_ready");
        check_eq("tmo_err_sticky", err_timeout, 1);

        // lock loss while idle
        rst_cnt = 0;
        pll_lock = 1'b0;
`ifdef PLL_LOCK_WATCHDOG_EN
        n = 0;
        while (!pll_rst && n < 10) begin
            tick();
            n++;
        end
        check_eq("wd_rst_latency", n, 3);
        check_eq("wd_ready", req_ready, 0);
        pll_lock = 1'b1;
        wait_ready(60, "wd_recover_ready");
        check_eq("wd_rst_cycles", rst_cnt, HOLD);
`else
        repeat (5) tick();
        check_eq("nowd_pll_rst", pll_rst, 0);
        check_eq("nowd_ready", req_ready, 0);
        check_eq("nowd_busy", busy, 0);
        check_eq("nowd_lock_ok", lock_ok, 0);
        check_eq("nowd_rst_cycles", rst_cnt, 0);
        pll_lock = 1'b1;
        repeat (3) tick();
        check_eq("nowd_ready_back", req_ready, 1);
`endif

        send(1, 1, 1, 1'b1, t);
        drain(40);
        check_eq("final_sel", phase_sel, 1);
        check_eq("final_dir", phase_dir, 1);
        repeat (3) tick();
        check_eq("final_events_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
